// File: rtl/isa_pkg.sv
// Shared ISA constants for the 16-bit teaching processor.
// Holds the 3-bit opcode encodings, the position of the opcode field, the
// fetch FSM state type and a small opcode helper. The fetch unit and the
// decode stage both import this package.
package isa_pkg;

  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned OPC_MSB = 8;

  localparam logic [2:0] OPC_MV  = 3'b000;
  localparam logic [2:0] OPC_MVI = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;
  localparam logic [2:0] OPC_OR  = 3'b100;
  localparam logic [2:0] OPC_SLT = 3'b101;
  localparam logic [2:0] OPC_SLL = 3'b110;
  localparam logic [2:0] OPC_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_IMM   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // True when the opcode field selects MVI, which carries a second word.
  function automatic logic is_mvi(input logic [2:0] opc);
    return opc == OPC_MVI;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator.
// Drives the word address of a combinational instruction ROM, captures the
// instruction (and, for MVI, the following immediate word) and offers the
// complete instruction to the control FSM over a valid/ready handshake.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   o_mem_addr           registered ROM word address
//   i_mem_data           ROM word at o_mem_addr (same cycle)
//   o_ir_valid/i_ir_ready  instruction handshake
//   o_ir_instr, o_ir_imm, o_ir_has_imm, o_ir_pc  instruction payload
//   i_redirect, i_redirect_addr  restart fetch at a new address
//   o_done               fetch stopped after last word (WRAP_EN=0)
//   o_fetch_err          sticky: MVI at last address with no room for imm
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned WRAP_EN    = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_ir_valid,
  input  logic              i_ir_ready,
  output logic [DATA_W-1:0] o_ir_instr,
  output logic [DATA_W-1:0] o_ir_imm,
  output logic              o_ir_has_imm,
  output logic [ADDR_W-1:0] o_ir_pc,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic              o_done,
  output logic              o_fetch_err
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_ir_instr;
  logic [DATA_W-1:0] r_ir_imm;
  logic              r_ir_has_imm;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_last;
  logic              r_fetch_err;

  logic              w_is_mvi;
  logic              w_at_last;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr_seq;

  assign w_is_mvi  = is_mvi(i_mem_data[OPC_MSB:OPC_LSB]);
  // Only meaningful without wrap: the top address is the final word.
  assign w_at_last = (WRAP_EN == 0) && (r_mem_addr == '1);
  assign w_xfer    = (r_state == ST_HOLD) && i_ir_ready;
  // Address holds at the last word when not wrapping; otherwise mod 2^ADDR_W.
  assign w_addr_seq = w_at_last ? r_mem_addr : r_mem_addr + ADDR_W'(1);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_FETCH;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: w_next_state = (w_is_mvi && !w_at_last) ? ST_IMM : ST_HOLD;
      ST_IMM:   w_next_state = ST_HOLD;
      ST_HOLD:  if (w_xfer) w_next_state = r_last ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next_state = ST_DONE;
      default:  w_next_state = ST_FETCH;
    endcase
    if (i_redirect) w_next_state = ST_FETCH;
  end

  // Fetch datapath: PC advance, last flag, instruction capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_addr   <= START;
      r_ir_instr   <= '0;
      r_ir_imm     <= '0;
      r_ir_has_imm <= 1'b0;
      r_ir_pc      <= '0;
      r_last       <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else if (i_redirect) begin
      r_mem_addr <= i_redirect_addr;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir_instr   <= i_mem_data;
          r_ir_pc      <= r_mem_addr;
          r_ir_has_imm <= w_is_mvi;
          r_mem_addr   <= w_addr_seq;
          r_last       <= w_at_last;
          // Immediate is cleared unless a real immediate word follows.
          if (!(w_is_mvi && !w_at_last)) r_ir_imm <= '0;
          if (w_is_mvi && w_at_last)     r_fetch_err <= 1'b1;
        end
        ST_IMM: begin
          r_ir_imm   <= i_mem_data;
          r_mem_addr <= w_addr_seq;
          r_last     <= w_at_last;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_ir_valid   = (r_state == ST_HOLD);
    o_done       = (r_state == ST_DONE);
    o_mem_addr   = r_mem_addr;
    o_ir_instr   = r_ir_instr;
    o_ir_imm     = r_ir_imm;
    o_ir_has_imm = r_ir_has_imm;
    o_ir_pc      = r_ir_pc;
    o_fetch_err  = r_fetch_err;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [32];

  // Instance A: WRAP_EN=1
  logic        rst_a = 1'b1, rdy_a = 1'b1, redir_a = 1'b0;
  logic [4:0]  raddr_a = '0, addr_a, pc_a;
  logic [15:0] data_a, instr_a, imm_a;
  logic        valid_a, has_imm_a, done_a, err_a;
  // Instance B: WRAP_EN=0
  logic        rst_b = 1'b1, rdy_b = 1'b1, redir_b = 1'b0;
  logic [4:0]  raddr_b = '0, addr_b, pc_b;
  logic [15:0] data_b, instr_b, imm_b;
  logic        valid_b, has_imm_b, done_b, err_b;

  assign data_a = rom[addr_a];
  assign data_b = rom[addr_b];

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(16), .START_ADDR(0), .WRAP_EN(1)) u_a (
    .i_clk(clk), .i_reset(rst_a), .o_mem_addr(addr_a), .i_mem_data(data_a),
    .o_ir_valid(valid_a), .i_ir_ready(rdy_a), .o_ir_instr(instr_a), .o_ir_imm(imm_a),
    .o_ir_has_imm(has_imm_a), .o_ir_pc(pc_a), .i_redirect(redir_a),
    .i_redirect_addr(raddr_a), .o_done(done_a), .o_fetch_err(err_a)
  );

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(16), .START_ADDR(0), .WRAP_EN(0)) u_b (
    .i_clk(clk), .i_reset(rst_b), .o_mem_addr(addr_b), .i_mem_data(data_b),
    .o_ir_valid(valid_b), .i_ir_ready(rdy_b), .o_ir_instr(instr_b), .o_ir_imm(imm_b),
    .o_ir_has_imm(has_imm_b), .o_ir_pc(pc_b), .i_redirect(redir_b),
    .i_redirect_addr(raddr_b), .o_done(done_b), .o_fetch_err(err_b)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rst_a_valid got=%0d exp=0", valid_a); end
    total++; if (addr_a !== 5'd0) begin bad++; $display("FAIL rst_a_addr got=%0d exp=0", addr_a); end
    total++; if (instr_a !== 16'h0) begin bad++; $display("FAIL rst_a_instr got=%h exp=0", instr_a); end
    total++; if (done_a !== 1'b0 || err_a !== 1'b0) begin bad++; $display("FAIL rst_a_flags got=%0d%0d exp=00", done_a, err_a); end
    total++; if (valid_b !== 1'b0 || done_b !== 1'b0) begin bad++; $display("FAIL rst_b_flags got=%0d%0d exp=00", valid_b, done_b); end
  endtask

  task automatic test_mvi_start();
    rst_a = 1'b0;
    @(negedge clk);  // after FETCH of the MVI: still in IMM
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL mvi_early_valid got=%0d exp=0", valid_a); end
    @(negedge clk);
    total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL mvi_valid got=%0d exp=1", valid_a); end
    total++; if (instr_a !== 16'h0040) begin bad++; $display("FAIL mvi_instr got=%h exp=0040", instr_a); end
    total++; if (imm_a !== 16'h0002) begin bad++; $display("FAIL mvi_imm got=%h exp=0002", imm_a); end
    total++; if (has_imm_a !== 1'b1) begin bad++; $display("FAIL mvi_has_imm got=%0d exp=1", has_imm_a); end
    total++; if (pc_a !== 5'd0) begin bad++; $display("FAIL mvi_pc got=%0d exp=0", pc_a); end
    total++; if (addr_a !== 5'd2) begin bad++; $display("FAIL mvi_next_addr got=%0d exp=2", addr_a); end
  endtask

  task automatic test_single_word();
    // transfer, fetch 2, transfer, fetch 3, transfer -> FETCH at 4
    repeat (5) @(negedge clk);
    total++; if (valid_a !== 1'b0 || addr_a !== 5'd4) begin bad++; $display("FAIL sw_pre got valid=%0d addr=%0d exp valid=0 addr=4", valid_a, addr_a); end
    @(negedge clk);
    total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL sw_valid got=%0d exp=1", valid_a); end
    total++; if (instr_a !== 16'h0088) begin bad++; $display("FAIL sw_instr got=%h exp=0088", instr_a); end
    total++; if (has_imm_a !== 1'b0 || imm_a !== 16'h0) begin bad++; $display("FAIL sw_imm got has=%0d imm=%h exp has=0 imm=0000", has_imm_a, imm_a); end
    total++; if (pc_a !== 5'd4) begin bad++; $display("FAIL sw_pc got=%0d exp=4", pc_a); end
  endtask

  task automatic test_backpressure();
    rdy_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (valid_a !== 1'b1 || instr_a !== 16'h0088 || pc_a !== 5'd4 || addr_a !== 5'd5) begin
        bad++;
        $display("FAIL bp_stable[%0d] got valid=%0d instr=%h pc=%0d addr=%0d exp 1/0088/4/5", i, valid_a, instr_a, pc_a, addr_a);
      end
    end
    rdy_a = 1'b1;
    @(negedge clk);
    total++; if (valid_a !== 1'b0 || addr_a !== 5'd5) begin bad++; $display("FAIL bp_release got valid=%0d addr=%0d exp valid=0 addr=5", valid_a, addr_a); end
  endtask

  task automatic test_redirect_mid_mvi();
    @(negedge clk);  // MVI at 5 fetched, now in IMM
    total++; if (valid_a !== 1'b0 || addr_a !== 5'd6) begin bad++; $display("FAIL rd_imm got valid=%0d addr=%0d exp valid=0 addr=6", valid_a, addr_a); end
    redir_a = 1'b1; raddr_a = 5'd7;
    @(negedge clk);
    redir_a = 1'b0;
    total++; if (valid_a !== 1'b0 || addr_a !== 5'd7) begin bad++; $display("FAIL rd_restart got valid=%0d addr=%0d exp valid=0 addr=7", valid_a, addr_a); end
    @(negedge clk);
    total++; if (valid_a !== 1'b1 || instr_a !== 16'h00D1 || pc_a !== 5'd7) begin bad++; $display("FAIL rd_deliver got valid=%0d instr=%h pc=%0d exp 1/00d1/7", valid_a, instr_a, pc_a); end
    total++; if (has_imm_a !== 1'b0) begin bad++; $display("FAIL rd_has_imm got=%0d exp=0", has_imm_a); end
  endtask

  task automatic test_wrap();
    redir_a = 1'b1; raddr_a = 5'd31;
    @(negedge clk);
    redir_a = 1'b0;
    @(negedge clk);
    total++; if (valid_a !== 1'b1 || pc_a !== 5'd31 || instr_a !== 16'h0) begin bad++; $display("FAIL wrap_31 got valid=%0d pc=%0d instr=%h exp 1/31/0000", valid_a, pc_a, instr_a); end
    total++; if (addr_a !== 5'd0) begin bad++; $display("FAIL wrap_addr got=%0d exp=0", addr_a); end
    repeat (3) @(negedge clk);
    total++; if (valid_a !== 1'b1 || pc_a !== 5'd0 || instr_a !== 16'h0040 || imm_a !== 16'h0002) begin bad++; $display("FAIL wrap_0 got valid=%0d pc=%0d instr=%h imm=%h exp 1/0/0040/0002", valid_a, pc_a, instr_a, imm_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL wrap_done got=%0d exp=0", done_a); end
  endtask

  task automatic test_stop_no_wrap();
    rst_b = 1'b0; redir_b = 1'b1; raddr_b = 5'd31;
    @(negedge clk);
    redir_b = 1'b0;
    @(negedge clk);
    total++; if (valid_b !== 1'b1 || pc_b !== 5'd31 || done_b !== 1'b0) begin bad++; $display("FAIL stop_31 got valid=%0d pc=%0d done=%0d exp 1/31/0", valid_b, pc_b, done_b); end
    total++; if (addr_b !== 5'd31) begin bad++; $display("FAIL stop_addr_hold got=%0d exp=31", addr_b); end
    @(negedge clk);
    total++; if (done_b !== 1'b1 || valid_b !== 1'b0) begin bad++; $display("FAIL stop_done got done=%0d valid=%0d exp 1/0", done_b, valid_b); end
    repeat (3) @(negedge clk);
    total++; if (done_b !== 1'b1 || valid_b !== 1'b0 || addr_b !== 5'd31) begin bad++; $display("FAIL stop_stay got done=%0d valid=%0d addr=%0d exp 1/0/31", done_b, valid_b, addr_b); end
    total++; if (err_b !== 1'b0) begin bad++; $display("FAIL stop_err got=%0d exp=0", err_b); end
  endtask

  task automatic test_last_mvi();
    rom[31] = 16'h0040;
    redir_b = 1'b1; raddr_b = 5'd31;
    @(negedge clk);
    redir_b = 1'b0;
    total++; if (done_b !== 1'b0) begin bad++; $display("FAIL lm_leave_done got=%0d exp=0", done_b); end
    @(negedge clk);
    total++; if (valid_b !== 1'b1 || has_imm_b !== 1'b1 || imm_b !== 16'h0) begin bad++; $display("FAIL lm_hold got valid=%0d has=%0d imm=%h exp 1/1/0000", valid_b, has_imm_b, imm_b); end
    total++; if (err_b !== 1'b1) begin bad++; $display("FAIL lm_err got=%0d exp=1", err_b); end
    @(negedge clk);
    total++; if (done_b !== 1'b1 || valid_b !== 1'b0 || err_b !== 1'b1) begin bad++; $display("FAIL lm_done got done=%0d valid=%0d err=%0d exp 1/0/1", done_b, valid_b, err_b); end
    // Re-enter HOLD, then reset while holding
    redir_b = 1'b1; raddr_b = 5'd31; rdy_b = 1'b0;
    @(negedge clk);
    redir_b = 1'b0;
    @(negedge clk);
    total++; if (valid_b !== 1'b1 || err_b !== 1'b1) begin bad++; $display("FAIL lm_rehold got valid=%0d err=%0d exp 1/1", valid_b, err_b); end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0; rdy_b = 1'b1;
    total++;
    if (valid_b !== 1'b0 || instr_b !== 16'h0 || imm_b !== 16'h0 || has_imm_b !== 1'b0 ||
        pc_b !== 5'd0 || addr_b !== 5'd0 || err_b !== 1'b0 || done_b !== 1'b0) begin
      bad++;
      $display("FAIL lm_reset got valid=%0d instr=%h imm=%h has=%0d pc=%0d addr=%0d err=%0d done=%0d exp all 0",
               valid_b, instr_b, imm_b, has_imm_b, pc_b, addr_b, err_b, done_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = 16'h0040;  // MVI R0
    rom[1] = 16'h0002;  //   #2
    rom[2] = 16'h0000;  // MV R0,R0
    rom[3] = 16'h00C8;  // SUB
    rom[4] = 16'h0088;  // ADD R1,R0
    rom[5] = 16'h0050;  // MVI
    rom[6] = 16'h1234;  //   imm
    rom[7] = 16'h00D1;  // SUB
    test_reset();
    test_mvi_start();
    test_single_word();
    test_backpressure();
    test_redirect_mid_mvi();
    test_wrap();
    test_stop_no_wrap();
    test_last_mvi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
